// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte-masked SRAM among NUM_REQ requesters,
// with burst grant locking, a lock watchdog and one-cycle registered response routing.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int LOCK_MAX   = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ-1:0]               req_wen_i,
    input  logic [NUM_REQ-1:0]               req_lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_bm_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_dat_i,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic                             rsp_wr_o,
    output logic [DATA_WIDTH-1:0]            rsp_dat_o,
    output logic                             sram_en_o,
    output logic                             sram_wen_o,
    output logic [DATA_WIDTH/8-1:0]          sram_bm_o,
    output logic [ADDR_WIDTH-1:0]            sram_addr_o,
    output logic [DATA_WIDTH-1:0]            sram_dat_o,
    input  logic [DATA_WIDTH-1:0]            sram_dat_i,
    output logic                             lock_abort_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam int BM_W  = DATA_WIDTH / 8;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    lock_state_e        r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_lock_owner, w_lock_owner_nxt;
    logic [CNT_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic               w_abort_nxt;
    logic               r_lock_abort;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_wr;
    logic               r_rsp_rd;

    logic               w_hs;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_grant_inc;
    logic [PTR_W-1:0]   w_owner_inc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_hs        = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (r_state == LOCKED) begin
            if (req_valid_i[r_lock_owner]) begin
                w_hs        = 1'b1;
                w_grant_idx = r_lock_owner;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_cand = PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
                if (!w_hs && req_valid_i[w_cand]) begin
                    w_hs        = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
        // Nothing is granted while reset is held.
        w_hs = w_hs & rst_n_i;
    end

    assign w_grant_inc = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_owner_inc = (r_lock_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_lock_owner + 1'b1;

    always_comb begin
        req_ready_o = '0;
        sram_en_o   = 1'b0;
        sram_wen_o  = 1'b0;
        sram_bm_o   = '0;
        sram_addr_o = '0;
        sram_dat_o  = '0;
        if (w_hs) begin
            req_ready_o[w_grant_idx] = 1'b1;
            sram_en_o   = 1'b1;
            sram_wen_o  = req_wen_i[w_grant_idx];
            sram_bm_o   = req_bm_i[w_grant_idx*BM_W +: BM_W];
            sram_addr_o = req_addr_i[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            sram_dat_o  = req_dat_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_owner_nxt = r_lock_owner;
        w_lock_cnt_nxt   = r_lock_cnt;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_abort_nxt      = 1'b0;
        unique case (r_state)
            UNLOCKED: begin
                if (w_hs) begin
                    if (req_lock_i[w_grant_idx]) begin
                        w_state_nxt      = LOCKED;
                        w_lock_owner_nxt = w_grant_idx;
                        w_lock_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_rr_ptr_nxt = w_grant_inc;
                    end
                end
            end
            LOCKED: begin
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                if (w_hs && !req_lock_i[w_grant_idx]) begin
                    w_state_nxt    = UNLOCKED;
                    w_lock_cnt_nxt = '0;
                    w_rr_ptr_nxt   = w_grant_inc;
                end else if (r_lock_cnt == CNT_W'(LOCK_MAX)) begin
                    // Watchdog: a beat in this cycle is still served, then the lock is broken.
                    w_state_nxt    = UNLOCKED;
                    w_lock_cnt_nxt = '0;
                    w_abort_nxt    = 1'b1;
                    w_rr_ptr_nxt   = w_owner_inc;
                end
            end
            default: w_state_nxt = UNLOCKED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= UNLOCKED;
            r_lock_owner <= '0;
            r_lock_cnt   <= '0;
            r_rr_ptr     <= '0;
            r_lock_abort <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_wr     <= 1'b0;
            r_rsp_rd     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_lock_abort <= w_abort_nxt;
            r_rsp_valid  <= req_ready_o;
            r_rsp_wr     <= w_hs & sram_wen_o;
            r_rsp_rd     <= w_hs & ~sram_wen_o;
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_wr_o     = r_rsp_wr;
    assign rsp_dat_o    = r_rsp_rd ? sram_dat_i : '0;
    assign lock_abort_o = r_lock_abort;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed-vector bench for sram_port_arbiter with a behavioural 1-cycle-latency byte-masked SRAM.
module tb_sram_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     valid, ready, wen, lock, rsp_valid;
    logic [NR*AW-1:0]  addr;
    logic [NR*BW-1:0]  bm;
    logic [NR*DW-1:0]  dat;
    logic              rsp_wr, sram_en, sram_wen, lock_abort;
    logic [DW-1:0]     rsp_dat, sram_dat_o, sram_rdata;
    logic [BW-1:0]     sram_bm;
    logic [AW-1:0]     sram_addr;

    logic [DW-1:0]     mem [512];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(valid), .req_ready_o(ready), .req_wen_i(wen), .req_lock_i(lock),
        .req_addr_i(addr), .req_bm_i(bm), .req_dat_i(dat),
        .rsp_valid_o(rsp_valid), .rsp_wr_o(rsp_wr), .rsp_dat_o(rsp_dat),
        .sram_en_o(sram_en), .sram_wen_o(sram_wen), .sram_bm_o(sram_bm),
        .sram_addr_o(sram_addr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_rdata),
        .lock_abort_o(lock_abort)
    );

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[9'h10] = 64'hDEAD;
        for (int i = 0; i < 4; i++) mem[9'h20 + i] = 64'h100 + 64'(i);
        for (int i = 0; i < 3; i++) mem[9'h30 + i] = '1;
    end

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen) begin
                for (int b = 0; b < BW; b++)
                    if (sram_bm[b]) mem[sram_addr][b*8 +: 8] <= sram_dat_o[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        valid = '0; wen = '0; lock = '0; addr = '0; bm = '0; dat = '0;
    endtask

    task automatic set_req(input int r, input logic w, input logic l, input logic [AW-1:0] a,
                           input logic [BW-1:0] m, input logic [DW-1:0] d);
        valid[r] = 1'b1; wen[r] = w; lock[r] = l;
        addr[r*AW +: AW] = a; bm[r*BW +: BW] = m; dat[r*DW +: DW] = d;
    endtask

    // Advance to the next negedge; inputs are driven there and outputs sampled 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        sram_rdata = '0;
        clr();
        tick(); tick();

        // Reset gating with a pending request.
        set_req(0, 1'b0, 1'b0, 9'h10, '0, '0);
        #1;
        chk("rst_ready", ready, 4'b0000);
        chk("rst_en", sram_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_abort", lock_abort, 1'b0);

        // 1: single read of 0x10.
        tick(); rst_n = 1'b1; #1;
        chk("t1_ready", ready, 4'b0001);
        chk("t1_en", sram_en, 1'b1);
        chk("t1_wen", sram_wen, 1'b0);
        chk("t1_addr", sram_addr, 9'h10);
        tick(); clr(); #1;
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_dat", rsp_dat, 64'hDEAD);
        chk("t1_rsp_wr", rsp_wr, 1'b0);
        chk("t1_idle_ready", ready, 4'b0000);

        // 2: full contention after a fresh reset -> 0,1,2,3,0.
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 1'b0, 9'(9'h20 + r), '0, '0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            #1;
            chk($sformatf("t2_ready%0d", k), ready, 64'(1) << (k % 4));
            if (k > 0) begin
                chk($sformatf("t2_rsp_valid%0d", k), rsp_valid, 64'(1) << ((k - 1) % 4));
                chk($sformatf("t2_rsp_dat%0d", k), rsp_dat, 64'h100 + 64'((k - 1) % 4));
            end
        end
        tick(); clr(); #1;
        chk("t2_rsp_last", rsp_valid, 4'b0001);

        // Move rr_ptr to 2 with a lone req1 read.
        tick(); set_req(1, 1'b0, 1'b0, 9'h20, '0, '0); #1;
        chk("t3_pre_ready", ready, 4'b0010);

        // 3: req2 locked 3-beat masked write while req0/req1 contend.
        tick(); clr();
        set_req(0, 1'b0, 1'b0, 9'h31, '0, '0);
        set_req(1, 1'b0, 1'b0, 9'h20, '0, '0);
        set_req(2, 1'b1, 1'b1, 9'h30, 8'h0F, 64'hA5A5_A5A5_0000_0001);
        #1;
        chk("t3_b0_ready", ready, 4'b0100);
        chk("t3_b0_wen", sram_wen, 1'b1);
        chk("t3_b0_bm", sram_bm, 8'h0F);
        tick(); set_req(2, 1'b1, 1'b1, 9'h31, 8'h0F, 64'hA5A5_A5A5_1234_5678); #1;
        chk("t3_b1_ready", ready, 4'b0100);
        chk("t3_b1_addr", sram_addr, 9'h31);
        chk("t3_b0_rsp_valid", rsp_valid, 4'b0100);
        chk("t3_b0_rsp_wr", rsp_wr, 1'b1);
        chk("t3_b0_rsp_dat", rsp_dat, 64'h0);
        tick(); set_req(2, 1'b1, 1'b0, 9'h32, 8'h0F, 64'hA5A5_A5A5_0000_0003); #1;
        chk("t3_b2_ready", ready, 4'b0100);
        tick(); valid[2] = 1'b0; #1;
        chk("t3_after_ready", ready, 4'b0001);
        tick(); valid[0] = 1'b0; #1;
        chk("t3_rd_rsp_valid", rsp_valid, 4'b0001);
        chk("t3_rd_rsp_dat", rsp_dat, 64'hFFFF_FFFF_1234_5678);
        chk("t3_rd_rsp_wr", rsp_wr, 1'b0);
        chk("t3_next_ready", ready, 4'b0010);
        tick(); clr(); #1;
        chk("t3_req1_rsp", rsp_valid, 4'b0010);

        // 4: req1 locks then stalls; watchdog releases after 16 cycles.
        tick(); set_req(1, 1'b0, 1'b1, 9'h20, '0, '0); #1;
        chk("t4_lock_ready", ready, 4'b0010);
        tick(); clr();
        set_req(0, 1'b0, 1'b0, 9'h20, '0, '0);
        set_req(2, 1'b0, 1'b0, 9'h21, '0, '0);
        set_req(3, 1'b0, 1'b0, 9'h22, '0, '0);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            #1;
            chk($sformatf("t4_stall_ready%0d", k), ready, 4'b0000);
            chk($sformatf("t4_stall_abort%0d", k), lock_abort, 1'b0);
        end
        tick(); #1;
        chk("t4_abort", lock_abort, 1'b1);
        chk("t4_regrant", ready, 4'b0100);
        tick(); clr(); #1;
        chk("t4_abort_pulse", lock_abort, 1'b0);

        // Watchdog firing on a cycle that also carries a locked beat.
        tick(); set_req(1, 1'b0, 1'b1, 9'h20, '0, '0); #1;
        chk("tw_lock_ready", ready, 4'b0010);
        tick(); set_req(2, 1'b0, 1'b0, 9'h21, '0, '0);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            #1;
            chk($sformatf("tw_beat_ready%0d", k), ready, 4'b0010);
        end
        tick(); #1;
        chk("tw_abort", lock_abort, 1'b1);
        chk("tw_regrant", ready, 4'b0100);
        tick(); clr(); #1;
        chk("tw_last_rsp", rsp_valid, 4'b0100);

        // 5: write then immediate read of the same word by another requester.
        tick(); set_req(3, 1'b1, 1'b0, 9'h5, 8'hFF, {8{8'hAA}}); #1;
        chk("t5_wr_ready", ready, 4'b1000);
        tick(); clr(); set_req(0, 1'b0, 1'b0, 9'h5, '0, '0); #1;
        chk("t5_rd_ready", ready, 4'b0001);
        chk("t5_wr_rsp_valid", rsp_valid, 4'b1000);
        chk("t5_wr_rsp_wr", rsp_wr, 1'b1);
        tick(); clr(); #1;
        chk("t5_rd_rsp_valid", rsp_valid, 4'b0001);
        chk("t5_rd_rsp_wr", rsp_wr, 1'b0);
        chk("t5_rd_rsp_dat", rsp_dat, {8{8'hAA}});

        // 6: reset the cycle after a read handshake; response dropped, rr_ptr restarts at 0.
        tick(); set_req(0, 1'b0, 1'b0, 9'h10, '0, '0); #1;
        chk("t6_ready", ready, 4'b0001);
        tick(); clr(); rst_n = 1'b0; #1;
        chk("t6_rsp_dropped", rsp_valid, 4'b0000);
        chk("t6_rsp_dat", rsp_dat, 64'h0);
        tick(); rst_n = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 1'b0, 9'(9'h20 + r), '0, '0);
        #1;
        chk("t6_rsp_still0", rsp_valid, 4'b0000);
        chk("t6_req0_wins", ready, 4'b0001);
        tick(); clr(); #1;
        chk("t6_rsp_after", rsp_valid, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
